// File: rtl/ltc2308_ctrl.sv
// LTC2308 SAR ADC master: CONVST pulse, conversion wait, then one 12-bit SPI frame
// that shifts the next configuration word out while the current sample comes in.
`timescale 1ns/1ps
module ltc2308_ctrl #(
    parameter int unsigned CONVST_CYC = 2,
    parameter int unsigned TCONV_CYC  = 80,
    parameter int unsigned SCK_HALF   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  cfg_ch,
    input  logic        cfg_sd,
    input  logic        cfg_uni,
    input  logic        cfg_slp,
    output logic        busy,
    output logic        result_valid,
    output logic [11:0] result_data,
    output logic [2:0]  result_ch,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);
    localparam int unsigned CNT_W = $clog2(TCONV_CYC + 1);
    localparam int unsigned PH_W  = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // SDI value for frame bit k: config word MSB first, zeros after the sixth bit.
    function automatic logic cfg_bit(input logic [5:0] word, input logic [3:0] k);
        logic b;
        if (k < 4'd6) begin
            b = word[3'd5 - k[2:0]];
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [PH_W-1:0]   ph_r, ph_s;
    logic [3:0]        bit_r, bit_s;
    logic [5:0]        cfg_word_r, cfg_word_s;
    logic [11:0]       shreg_r, shreg_s;
    logic [2:0]        prev_ch_r, prev_ch_s;
    logic              have_prev_r, have_prev_s;
    logic              convst_r, convst_s;
    logic              sck_r, sck_s;
    logic              sdi_r, sdi_s;
    logic              busy_r, busy_s;
    logic              valid_r, valid_s;
    logic [11:0]       data_r, data_s;
    logic [2:0]        rch_r, rch_s;

    assign busy         = busy_r;
    assign result_valid = valid_r;
    assign result_data  = data_r;
    assign result_ch    = rch_r;
    assign adc_convst   = convst_r;
    assign adc_sck      = sck_r;
    assign adc_sdi      = sdi_r;

    // State and every output pin/result register; reset forces all pins low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            ph_r        <= '0;
            bit_r       <= 4'd0;
            cfg_word_r  <= 6'd0;
            shreg_r     <= 12'd0;
            prev_ch_r   <= 3'd0;
            have_prev_r <= 1'b0;
            convst_r    <= 1'b0;
            sck_r       <= 1'b0;
            sdi_r       <= 1'b0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            data_r      <= 12'd0;
            rch_r       <= 3'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ph_r        <= ph_s;
            bit_r       <= bit_s;
            cfg_word_r  <= cfg_word_s;
            shreg_r     <= shreg_s;
            prev_ch_r   <= prev_ch_s;
            have_prev_r <= have_prev_s;
            convst_r    <= convst_s;
            sck_r       <= sck_s;
            sdi_r       <= sdi_s;
            busy_r      <= busy_s;
            valid_r     <= valid_s;
            data_r      <= data_s;
            rch_r       <= rch_s;
        end
    end

    // Next-state and next-output logic; the counter runs from the CONVST rise through WAIT.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        ph_s        = ph_r;
        bit_s       = bit_r;
        cfg_word_s  = cfg_word_r;
        shreg_s     = shreg_r;
        prev_ch_s   = prev_ch_r;
        have_prev_s = have_prev_r;
        convst_s    = 1'b0;
        sck_s       = sck_r;
        sdi_s       = sdi_r;
        busy_s      = busy_r;
        valid_s     = 1'b0;
        data_s      = data_r;
        rch_s       = rch_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_CONV;
                    cfg_word_s = {cfg_sd, cfg_ch, cfg_uni, cfg_slp};
                    cnt_s      = '0;
                    convst_s   = 1'b1;
                    busy_s     = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_CONV: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(CONVST_CYC - 1)) begin
                    state_s  = ST_WAIT;
                    convst_s = 1'b0;
                end else begin
                    convst_s = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(TCONV_CYC - 1)) begin
                    state_s = ST_SHIFT;
                    ph_s    = '0;
                    bit_s   = 4'd0;
                    sck_s   = 1'b0;
                    sdi_s   = cfg_bit(cfg_word_r, 4'd0);
                end else begin
                    sdi_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (ph_r == PH_W'(SCK_HALF - 1)) begin
                    ph_s = '0;
                    if (!sck_r) begin
                        sck_s = 1'b1;
                    end else begin
                        // Falling edge: capture SDO while SCK is still high, then present next SDI.
                        sck_s   = 1'b0;
                        shreg_s = {shreg_r[10:0], adc_sdo};
                        if (bit_r == 4'd11) begin
                            state_s = ST_DONE;
                            sdi_s   = 1'b0;
                        end else begin
                            bit_s = bit_r + 4'd1;
                            sdi_s = cfg_bit(cfg_word_r, bit_r + 4'd1);
                        end
                    end
                end else begin
                    ph_s = ph_r + PH_W'(1);
                end
            end
            ST_DONE: begin
                state_s     = ST_IDLE;
                busy_s      = 1'b0;
                valid_s     = have_prev_r;
                rch_s       = prev_ch_r;
                prev_ch_s   = cfg_word_r[4:2];
                have_prev_s = 1'b1;
                if (have_prev_r) begin
                    data_s = shreg_r;
                end else begin
                    data_s = data_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                sck_s   = 1'b0;
                sdi_s   = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Bench for ltc2308_ctrl: two DUTs (SCK_HALF=2 and 1) share one LTC2308 behavioural model.
`timescale 1ns/1ps
module tb_ltc2308_ctrl;
    localparam int TCONV = 80;
    localparam int CVW   = 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [2:0] cfg_ch;
    logic       cfg_sd, cfg_uni, cfg_slp;
    bit         sel;
    bit         model_en;
    logic       start0, start1;
    assign start0 = start && !sel;
    assign start1 = start && sel;

    logic        busy0, valid0, convst0, sck0, sdi0;
    logic [11:0] data0;
    logic [2:0]  rch0;
    logic        busy1, valid1, convst1, sck1, sdi1;
    logic [11:0] data1;
    logic [2:0]  rch1;
    logic        adc_sdo;

    ltc2308_ctrl #(.CONVST_CYC(CVW), .TCONV_CYC(TCONV), .SCK_HALF(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cfg_ch(cfg_ch), .cfg_sd(cfg_sd),
        .cfg_uni(cfg_uni), .cfg_slp(cfg_slp), .busy(busy0), .result_valid(valid0),
        .result_data(data0), .result_ch(rch0), .adc_convst(convst0), .adc_sck(sck0),
        .adc_sdi(sdi0), .adc_sdo(adc_sdo));

    ltc2308_ctrl #(.CONVST_CYC(CVW), .TCONV_CYC(TCONV), .SCK_HALF(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cfg_ch(cfg_ch), .cfg_sd(cfg_sd),
        .cfg_uni(cfg_uni), .cfg_slp(cfg_slp), .busy(busy1), .result_valid(valid1),
        .result_data(data1), .result_ch(rch1), .adc_convst(convst1), .adc_sck(sck1),
        .adc_sdi(sdi1), .adc_sdo(adc_sdo));

    logic        m_busy, m_valid, m_convst, m_sck, m_sdi;
    logic [11:0] m_data;
    logic [2:0]  m_rch;
    assign m_busy   = sel ? busy1   : busy0;
    assign m_valid  = sel ? valid1  : valid0;
    assign m_convst = sel ? convst1 : convst0;
    assign m_sck    = sel ? sck1    : sck0;
    assign m_sdi    = sel ? sdi1    : sdi0;
    assign m_data   = sel ? data1   : data0;
    assign m_rch    = sel ? rch1    : rch0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ADC model: channel k reads {3{F-k}}; config word of frame N selects the conversion of frame N+1
    logic [11:0] m_sreg = 12'd0;
    logic [5:0]  m_rx   = 6'd0;
    int          m_rx_cnt = 6;
    logic [2:0]  m_pend = 3'd0;
    time         t_cv_rise = 0;
    time         t_sdi = 0;
    assign adc_sdo = m_sreg[11];

    function automatic logic [11:0] ch_val(input logic [2:0] c);
        logic [3:0] nib;
        nib = 4'hF - {1'b0, c};
        return {nib, nib, nib};
    endfunction

    always @(posedge m_convst) if (model_en) begin
        t_cv_rise = $time;
        m_sreg    = ch_val(m_pend);
        m_rx_cnt  = 0;
    end
    always @(negedge m_convst) if (model_en) chk("convst_width_ns", 32'(($time - t_cv_rise) >= 20), 32'd1);
    always @(m_sdi) t_sdi = $time;
    always @(posedge m_sck) if (model_en) begin
        chk("sdi_setup_ns", 32'(($time - t_sdi) >= 10), 32'd1);
        if (m_rx_cnt < 6) begin
            m_rx = {m_rx[4:0], m_sdi};
            m_rx_cnt++;
            if (m_rx_cnt == 6) m_pend = m_rx[4:2];
        end
    end
    always @(negedge m_sck) if (model_en) m_sreg <= {m_sreg[10:0], 1'b0};

    typedef struct {
        logic [2:0]  ch;
        logic        sd, uni, slp;
        logic [5:0]  word;
        logic        vld;
        logic [2:0]  ech;
        logic [11:0] edata;
    } vec_t;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
    } res_t;

    res_t exp_q[$];
    vec_t vecs[6];

    // One frame: drive start (unless already accepted), watch pins cycle by cycle until busy drops.
    task automatic run_frame(input vec_t v, input int h, input bit pulse, input bit pre);
        int cv_w, cv_rise, rises, first_rise, vcnt, fall_n;
        logic [11:0] sdi_bits;
        logic pcv, psck;
        res_t r;
        cv_w = 0; cv_rise = 0; rises = 0; first_rise = -1; vcnt = 0; fall_n = -1;
        sdi_bits = 12'd0; pcv = 1'b0; psck = 1'b0;
        if (!pre) begin
            @(negedge clk);
            cfg_ch = v.ch; cfg_sd = v.sd; cfg_uni = v.uni; cfg_slp = v.slp;
            start = 1'b1;
            @(posedge clk);
        end
        if (v.vld) begin
            r.ch = v.ech;
            r.data = v.edata;
            exp_q.push_back(r);
        end
        @(negedge clk);
        if (!pulse) start = 1'b0;
        chk("accept_convst", 32'(m_convst), 32'd1);
        chk("accept_busy", 32'(m_busy), 32'd1);
        for (int n = 0; n < 400; n++) begin
            if (m_convst) cv_w++;
            if (m_convst && !pcv) cv_rise++;
            if (m_sck && !psck) begin
                if (rises == 0) first_rise = n;
                sdi_bits = {sdi_bits[10:0], m_sdi};
                rises++;
            end
            if (m_valid) begin
                vcnt++;
                chk("valid_latency", n, TCONV + 24 * h + 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("result_ch", 32'(m_rch), 32'(r.ch));
                    chk("result_data", 32'(m_data), 32'(r.data));
                end
            end
            pcv = m_convst;
            psck = m_sck;
            if (!m_busy) begin
                fall_n = n;
                break;
            end
            @(negedge clk);
        end
        chk("busy_fall", fall_n, TCONV + 24 * h + 1);
        chk("convst_cycles", cv_w, CVW);
        chk("convst_pulses", cv_rise, 1);
        chk("first_sck_rise", first_rise, TCONV + h);
        chk("sck_periods", rises, 12);
        chk("sdi_cfg_word", 32'(sdi_bits[11:6]), 32'(v.word));
        chk("sdi_tail_zero", 32'(sdi_bits[5:0]), 32'd0);
        chk("sck_idle_low", 32'(m_sck), 32'd0);
        chk("valid_count", vcnt, 32'(v.vld));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t pv;
        int rises;
        bit found;
        logic psck;
        rst_n = 1'b1; start = 1'b0; sel = 1'b0; model_en = 1'b0;
        cfg_ch = 3'd0; cfg_sd = 1'b0; cfg_uni = 1'b0; cfg_slp = 1'b0;
        vecs[0] = '{3'd0, 1'b1, 1'b0, 1'b0, 6'b100000, 1'b0, 3'd0, 12'h000};
        vecs[1] = '{3'd1, 1'b1, 1'b0, 1'b0, 6'b100100, 1'b1, 3'd0, 12'hFFF};
        vecs[2] = '{3'd2, 1'b1, 1'b0, 1'b0, 6'b101000, 1'b1, 3'd1, 12'hEEE};
        vecs[3] = '{3'd5, 1'b1, 1'b1, 1'b0, 6'b110110, 1'b1, 3'd2, 12'hDDD};
        vecs[4] = '{3'd7, 1'b0, 1'b0, 1'b1, 6'b011101, 1'b1, 3'd5, 12'hAAA};
        vecs[5] = '{3'd3, 1'b1, 1'b1, 1'b1, 6'b101111, 1'b1, 3'd7, 12'h888};
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_convst", 32'(convst0 | convst1), 32'd0);
        chk("rst_sck", 32'(sck0 | sck1), 32'd0);
        chk("rst_sdi", 32'(sdi0 | sdi1), 32'd0);
        chk("rst_busy", 32'(busy0 | busy1), 32'd0);
        chk("rst_valid", 32'(valid0 | valid1), 32'd0);
        chk("rst_data", 32'(data0 | data1), 32'd0);
        chk("rst_ch", 32'(rch0 | rch1), 32'd0);
        rst_n = 1'b1;
        model_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], 2, 1'b0, 1'b0);

        // start held high through a whole frame, then the back-to-back frame it triggers
        pv = '{3'd6, 1'b1, 1'b0, 1'b0, 6'b111000, 1'b1, 3'd3, 12'hCCC};
        run_frame(pv, 2, 1'b1, 1'b0);
        pv = '{3'd6, 1'b1, 1'b0, 1'b0, 6'b111000, 1'b1, 3'd6, 12'h999};
        run_frame(pv, 2, 1'b0, 1'b1);

        // reset during the high phase of SCK bit 7
        @(negedge clk);
        cfg_ch = 3'd4; cfg_sd = 1'b1; cfg_uni = 1'b0; cfg_slp = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rises = 0; found = 1'b0; psck = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (m_sck && !psck) rises++;
            psck = m_sck;
            if (rises == 8) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_bit7", 32'(found), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_convst", 32'(m_convst), 32'd0);
        chk("midrst_sck", 32'(m_sck), 32'd0);
        chk("midrst_sdi", 32'(m_sdi), 32'd0);
        chk("midrst_busy", 32'(m_busy), 32'd0);
        chk("midrst_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pv = '{3'd1, 1'b1, 1'b0, 1'b0, 6'b100100, 1'b0, 3'd0, 12'h000};
        run_frame(pv, 2, 1'b0, 1'b0);
        pv = '{3'd2, 1'b1, 1'b0, 1'b0, 6'b101000, 1'b1, 3'd1, 12'hEEE};
        run_frame(pv, 2, 1'b0, 1'b0);

        // SCK_HALF=1 instance
        @(negedge clk);
        sel = 1'b1;
        pv = '{3'd3, 1'b1, 1'b0, 1'b0, 6'b101100, 1'b0, 3'd0, 12'h000};
        run_frame(pv, 1, 1'b0, 1'b0);
        pv = '{3'd4, 1'b1, 1'b0, 1'b0, 6'b110000, 1'b1, 3'd3, 12'hCCC};
        run_frame(pv, 1, 1'b0, 1'b0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
